// File: rtl/otter_input_port.sv
// OTTER input port: synchronized switches, debounced buttons with rising-edge events,
// and an IO-bus register file. Define OTTER_INPUT_PORT_INTR_EN to build MASK and intr.
module otter_input_port #(
    parameter logic [15:0] DB_CYCLES = 16'd10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  buttons,
    input  logic [15:0] switches,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        intr
);

    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned SW_W    = 16;

    localparam logic [31:0] ADDR_SWITCHES = 32'h1100_8000;
    localparam logic [31:0] ADDR_BUTTONS  = 32'h1100_8004;
    localparam logic [31:0] ADDR_EVENTS   = 32'h1100_8010;
    localparam logic [31:0] ADDR_MASK     = 32'h1100_8014;

    localparam logic [15:0] DB_LAST = DB_CYCLES - 16'd1;

    logic [NUM_BTN-1:0] btn_meta;
    logic [NUM_BTN-1:0] btn_sync;
    logic [NUM_BTN-1:0] btn_db;
    logic [NUM_BTN-1:0] events;
    logic [NUM_BTN-1:0] mask;
    logic [NUM_BTN-1:0] rise_c;
    logic [NUM_BTN-1:0] clr_c;
    logic [SW_W-1:0]    sw_meta;
    logic [SW_W-1:0]    sw_sync;
    logic [15:0]        db_cnt [NUM_BTN];
    logic               wr_events_c;
    logic               unused_wdata;

    assign unused_wdata = ^IOBUS_OUT[31:NUM_BTN];

    // Two-flop synchronizers for every raw board input
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= buttons;
            btn_sync <= btn_meta;
            sw_meta  <= switches;
            sw_sync  <= sw_meta;
        end
    end

    // Debounce: the synchronized value must disagree for DB_CYCLES straight cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= 16'd0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (btn_sync[i] == btn_db[i]) begin
                    db_cnt[i] <= 16'd0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_db[i] <= btn_sync[i];
                    db_cnt[i] <= 16'd0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Rising edge of the debounced value, seen on the cycle it is about to update
    always_comb begin
        rise_c = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            rise_c[i] = btn_sync[i] & ~btn_db[i] & (db_cnt[i] == DB_LAST);
        end
    end

    assign wr_events_c = IOBUS_WR && (IOBUS_ADDR == ADDR_EVENTS);
    assign clr_c       = wr_events_c ? IOBUS_OUT[NUM_BTN-1:0] : '0;

    // Sticky events, W1C; a new edge overrides a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            events <= '0;
        end else begin
            events <= (events & ~clr_c) | rise_c;
        end
    end

`ifdef OTTER_INPUT_PORT_INTR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
            intr <= 1'b0;
        end else begin
            if (IOBUS_WR && (IOBUS_ADDR == ADDR_MASK)) begin
                mask <= IOBUS_OUT[NUM_BTN-1:0];
            end
            intr <= |(events & mask);
        end
    end
`else
    assign mask = '0;
    assign intr = 1'b0;
`endif

    // Side-effect-free read mux
    always_comb begin
        IOBUS_IN = 32'd0;
        case (IOBUS_ADDR)
            ADDR_SWITCHES: IOBUS_IN = 32'(sw_sync);
            ADDR_BUTTONS:  IOBUS_IN = 32'(btn_db);
            ADDR_EVENTS:   IOBUS_IN = 32'(events);
            ADDR_MASK:     IOBUS_IN = 32'(mask);
            default:       IOBUS_IN = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_otter_input_port.sv
// Scoreboard bench for otter_input_port: directed scenarios then random stimulus,
// checked against a cycle-level behavioural model of the port.
module tb_otter_input_port;

    localparam logic [15:0] DB = 16'd4;
`ifdef OTTER_INPUT_PORT_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif

    localparam logic [31:0] A_SW  = 32'h1100_8000;
    localparam logic [31:0] A_BTN = 32'h1100_8004;
    localparam logic [31:0] A_UNM = 32'h1100_8008;
    localparam logic [31:0] A_EV  = 32'h1100_8010;
    localparam logic [31:0] A_MSK = 32'h1100_8014;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  buttons = '0;
    logic [15:0] switches = '0;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_IN;
    logic        intr;

    otter_input_port #(.DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .buttons(buttons), .switches(switches),
        .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
        .IOBUS_IN(IOBUS_IN), .intr(intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        intr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: raw inputs reach the logic two samples late; a button's debounced
    // value follows once the late value has disagreed with it for DB samples in a row.
    bit [4:0]  m_s1, m_s2, m_db, m_ev, m_mask;
    bit [15:0] m_sw1, m_sw2;
    bit        m_intr;
    int        streak [5];

    always @(posedge clk) begin : model
        bit [4:0] rise;
        bit [4:0] clr;
        bit       nintr;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_ev = '0; m_mask = '0;
            m_sw1 = '0; m_sw2 = '0; m_intr = 1'b0;
            for (int i = 0; i < 5; i++) streak[i] = 0;
        end else begin
            rise = '0;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    streak[i] = streak[i] + 1;
                    if (streak[i] == int'(DB)) begin
                        m_db[i]   = m_s2[i];
                        rise[i]   = m_s2[i];
                        streak[i] = 0;
                    end
                end else begin
                    streak[i] = 0;
                end
            end
            clr    = (IOBUS_WR && IOBUS_ADDR == A_EV) ? IOBUS_OUT[4:0] : 5'd0;
            nintr  = INTR_EN && (|(m_ev & m_mask));
            m_ev   = (m_ev & ~clr) | rise;
            if (INTR_EN && IOBUS_WR && IOBUS_ADDR == A_MSK) m_mask = IOBUS_OUT[4:0];
            m_intr = nintr;
            m_s2 = m_s1; m_s1 = buttons;
            m_sw2 = m_sw1; m_sw1 = switches;
        end
    end

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        case (a)
            A_SW:    return 32'(m_sw2);
            A_BTN:   return 32'(m_db);
            A_EV:    return 32'(m_ev);
            A_MSK:   return 32'(m_mask);
            default: return 32'd0;
        endcase
    endfunction

    // One cycle of stimulus; the expected read and intr for this cycle go to the scoreboard
    task automatic drive(input bit r, input logic [4:0] b, input logic [15:0] s,
                         input logic [31:0] a, input logic [31:0] d, input bit w);
        exp_t e;
        rst = r; buttons = b; switches = s;
        IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = w;
        e.addr = a; e.data = exp_read(a); e.intr = m_intr;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare after inputs settle, mid low phase
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (IOBUS_IN !== e.data) begin
                    errors++;
                    $display("FAIL read addr=%h got=%h exp=%h t=%0t", e.addr, IOBUS_IN, e.data, $time);
                end
                checks++;
                if (intr !== e.intr) begin
                    errors++;
                    $display("FAIL intr got=%b exp=%b t=%0t", intr, e.intr, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return A_SW;
            1: return A_BTN;
            2: return A_UNM;
            3, 4: return A_EV;
            5: return A_MSK;
            default: return $urandom();
        endcase
    endfunction

    initial begin : stim
        logic [4:0]  b;
        logic [15:0] s;
        logic [31:0] a;
        @(negedge clk);
        drive(1, 0, 0, A_SW, 0, 0);
        drive(1, 0, 0, A_MSK, 32'h1F, 1);
        drive(0, 0, 0, A_EV, 0, 0);
        drive(0, 0, 0, A_MSK, 0, 0);
        // Switches pass through synchronizer; unmapped reads zero
        for (int i = 0; i < 4; i++) drive(0, 0, 16'hA5C3, A_SW, 0, 0);
        drive(0, 0, 16'hA5C3, A_UNM, 0, 0);
        // Short glitch on button 0 is rejected
        for (int i = 0; i < 3; i++) drive(0, 5'h01, 16'hA5C3, A_BTN, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 5'h00, 16'hA5C3, (i % 2) ? A_EV : A_BTN, 0, 0);
        // Held button debounces and raises its event
        for (int i = 0; i < 9; i++) drive(0, 5'h01, 16'hA5C3, (i % 2) ? A_EV : A_BTN, 0, 0);
        drive(0, 5'h01, 0, A_MSK, 32'h1, 1);
        drive(0, 5'h01, 0, A_EV, 0, 0);
        drive(0, 5'h01, 0, A_EV, 32'h1, 1);
        for (int i = 0; i < 3; i++) drive(0, 5'h01, 0, A_EV, 0, 0);
        // Release is not an event
        for (int i = 0; i < 8; i++) drive(0, 5'h00, 0, A_EV, 0, 0);
        // W1C of all bits on the very cycle event[2] sets
        drive(1, 0, 0, A_EV, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 5'h04, 0, A_EV, 0, 0);
        drive(0, 5'h04, 0, A_EV, 32'h1F, 1);
        for (int i = 0; i < 3; i++) drive(0, 5'h04, 0, A_EV, 0, 0);
        // Reset mid-debounce on button 1, held across reset
        drive(1, 0, 0, A_EV, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 5'h02, 0, A_BTN, 0, 0);
        drive(1, 5'h02, 0, A_EV, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 5'h02, 0, A_EV, 0, 0);
        // Writes to read-only and unmapped addresses do nothing
        drive(0, 5'h02, 16'h1234, A_SW, 32'hFFFF_FFFF, 1);
        drive(0, 5'h02, 16'h1234, A_BTN, 32'hFFFF_FFFF, 1);
        drive(0, 5'h02, 16'h1234, A_UNM, 32'hFFFF_FFFF, 1);
        drive(0, 5'h02, 16'h1234, A_SW, 0, 0);
        drive(0, 5'h02, 16'h1234, A_BTN, 0, 0);
        drive(0, 5'h02, 16'h1234, A_EV, 0, 0);
        // Random traffic
        b = 5'h02; s = 16'h1234;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 5; i++) if ($urandom_range(0, 15) == 0) b[i] = ~b[i];
            if ($urandom_range(0, 7) == 0) s = 16'($urandom());
            if ($urandom_range(0, 5) == 0) begin
                a = pick_addr();
                drive($urandom_range(0, 299) == 0, b, s, a, $urandom(), 1);
            end else begin
                drive($urandom_range(0, 299) == 0, b, s, pick_addr(), $urandom(), 0);
            end
        end
        drive(0, b, s, A_EV, 0, 0);
        @(negedge clk);
        #5;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
